// File: rtl/mem_read_pkg.sv
// rtl/mem_read_pkg.sv - shared state type and default widths for the memory read streamer
package mem_read_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with registered storage
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_clear,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;

    // Head word is shown as zero while empty so the stream outputs rest at zero.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/mem_read_streamer.sv
// rtl/mem_read_streamer.sv - walks a memory address range and streams the words with last flag and checksum
module mem_read_streamer
    import mem_read_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int             CW       = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    LP_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_pending;
    logic                r_pend_last;
    logic                r_done;
    logic [DATA_W-1:0]   r_checksum;

    logic                w_start_ok;
    logic                w_issue;
    logic                w_hs;
    logic [CW:0]         w_credit;
    logic [CW-1:0]       w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DATA_W:0]     w_fifo_rdata;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    // Words already buffered plus the read in flight must leave room for one more.
    assign w_credit   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_pending};
    assign w_issue    = (r_state == ST_RUN) && (r_remaining != '0) &&
                        (w_credit < LP_DEPTH) && !w_fifo_full;
    assign w_hs       = out_valid && out_ready;

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign mem_en    = w_issue;
    assign mem_addr  = r_addr;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_rdata[DATA_W-1:0];
    assign out_last  = w_fifo_rdata[DATA_W];
    assign checksum  = r_checksum;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_wr_en   (r_pending),
        .i_wr_data ({r_pend_last, mem_rdata}),
        .i_rd_en   (out_ready),
        .o_rd_data (w_fifo_rdata),
        .o_count   (w_fifo_count),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pending   <= 1'b0;
            r_pend_last <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_pending <= w_issue;
            if (w_issue) r_pend_last <= (r_remaining == LP_ONE);
            if (w_hs) r_checksum <= r_checksum + out_data;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= count;
                        r_checksum  <= '0;
                        if (count != '0) r_state <= ST_RUN;
                        else             r_done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - LP_ONE;
                        if (r_remaining == LP_ONE) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_hs && out_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_streamer.sv
// tb/tb_mem_read_streamer.sv - self-checking bench for mem_read_streamer
module tb_mem_read_streamer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  count = '0;
    logic        busy, done, mem_en, out_valid, out_last;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_ready = 1'b1;
    logic [31:0] out_data, checksum;

    logic [31:0] mem [256];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr];

    mem_read_streamer #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .checksum(checksum)
    );

    typedef struct {
        logic [7:0]  base;
        logic [8:0]  cnt;
        int          stall_lo;
        int          stall_hi;
        logic [31:0] exp_sum;
        int          exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: stream is mem[base+i] (mod 256) in order, last on the final one.
    task automatic run_xfer(input logic [7:0] base, input logic [8:0] cnt,
                            input int stall_lo, input int stall_hi, input bit rand_ready,
                            input bit restart, input int exp_done,
                            input logic [31:0] exp_sum, input bit use_exp_sum,
                            input string tag);
        logic [31:0] expq[$];
        logic [31:0] sum_m;
        logic [31:0] prev_data;
        logic        prev_last, prev_stall, exp_b;
        int got, derr, lerr, aerr, serr, berr, cerr, issued, dones, done_cyc, cyc, after, budget;
        sum_m = 0; prev_data = 0; prev_last = 0; prev_stall = 0;
        got = 0; derr = 0; lerr = 0; aerr = 0; serr = 0; berr = 0; cerr = 0;
        issued = 0; dones = 0; done_cyc = -1; cyc = 0; after = 0;
        budget = 4 * int'(cnt) + stall_hi + 60;
        for (int i = 0; i < int'(cnt); i++) begin
            expq.push_back(mem[8'(int'(base) + i)]);
            sum_m += mem[8'(int'(base) + i)];
        end
        @(negedge clock);
        start = 1'b1; base_addr = base; count = cnt; out_ready = 1'b1;
        @(posedge clock);
        while (cyc < budget) begin
            @(negedge clock);
            cyc++;
            start = restart && (cyc >= 2) && (cyc <= 4);
            if (restart) begin base_addr = ~base; count = cnt + 9'd1; end
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else            out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
            #1;
            if (mem_en) begin
                if (mem_addr !== 8'(int'(base) + issued)) aerr++;
                issued++;
            end
            if (issued - got > DEPTH) cerr++;
            if (prev_stall && !(out_valid && out_data === prev_data && out_last === prev_last)) serr++;
            if (out_valid && out_ready) begin
                if (got < int'(cnt)) begin
                    if (out_data !== expq[got]) derr++;
                    if (out_last !== (got == int'(cnt) - 1)) lerr++;
                end else derr++;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            exp_b = (cnt != 0) && (done_cyc < 0);
            if (busy !== exp_b) berr++;
            if (done_cyc >= 0) after++;
            if (after >= 3) break;
        end
        start = 1'b0; out_ready = 1'b1;
        chk({tag, " words"}, got, int'(cnt));
        chk({tag, " data"}, derr, 0);
        chk({tag, " last"}, lerr, 0);
        chk({tag, " addr"}, aerr, 0);
        chk({tag, " reads"}, issued, int'(cnt));
        chk({tag, " credit"}, cerr, 0);
        chk({tag, " stable"}, serr, 0);
        chk({tag, " busy"}, berr, 0);
        chk({tag, " done_pulses"}, dones, 1);
        chk({tag, " checksum"}, checksum, sum_m);
        if (use_exp_sum) chk({tag, " checksum_const"}, checksum, exp_sum);
        if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
    endtask

    initial begin
        vec_t vecs[6];
        int   n_words;
        int   exp_d;
        logic [7:0] b;
        bit   rr;

        for (int a = 0; a < 256; a++) mem[a] = 32'(a * 3);

        vecs[0] = '{8'h10, 9'd4,   0,  0, 32'h000000D2,   7};
        vecs[1] = '{8'h10, 9'd4,   3, 12, 32'h000000D2,  -1};
        vecs[2] = '{8'h10, 9'd8,   3, 12, 32'h000001D4,  -1};
        vecs[3] = '{8'hFE, 9'd4,   0,  0, 32'h000005FA,   7};
        vecs[4] = '{8'h00, 9'd0,   0,  0, 32'h00000000,   1};
        vecs[5] = '{8'h00, 9'd256, 0,  0, 32'h00017E80, 259};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset mem_en", mem_en, 0);
        chk("reset outs", {mem_addr, out_valid, out_last, out_data, checksum}, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].stall_lo, vecs[v].stall_hi, 1'b0, 1'b0,
                     vecs[v].exp_done, vecs[v].exp_sum, 1'b1, $sformatf("vec%0d", v));

        run_xfer(8'h20, 9'd6, 0, 0, 1'b0, 1'b1, 9, 32'h0, 1'b0, "restart");

        // Reset in cycle 4 of a count-8 transfer, then a clean restart.
        @(negedge clock);
        start = 1'b1; base_addr = 8'h40; count = 9'd8; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset mem_en", mem_en, 0);
        chk("midreset valid", out_valid, 0);
        chk("midreset outs", {mem_addr, out_last, out_data, checksum}, 0);
        reset = 1'b0;
        run_xfer(8'h10, 9'd4, 0, 0, 1'b0, 1'b0, 7, 32'h000000D2, 1'b1, "after_reset");

        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        for (int t = 0; t < 20; t++) begin
            b       = 8'($urandom_range(0, 255));
            n_words = $urandom_range(0, 40);
            rr      = (t % 3) != 0;
            exp_d   = rr ? -1 : ((n_words == 0) ? 1 : n_words + 3);
            run_xfer(b, 9'(n_words), 0, 0, rr, 1'b0, exp_d, 32'h0, 1'b0,
                     $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
